// File: rtl/scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package scan_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 32;

    localparam logic [SEG_W-1:0]      SEG_OFF = 7'h00;
    localparam logic [MAX_DIGITS-1:0] DIG_OFF = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // One-hot digit select for position pos, or all-off; callers truncate to their digit count.
    function automatic logic [MAX_DIGITS-1:0] dig_sel(input logic on, input int unsigned pos);
        return on ? (MAX_DIGITS'(1) << pos) : DIG_OFF;
    endfunction

endpackage

// File: rtl/segment_code.sv
// BCD to 7-segment decoder, {g,f,e,d,c,b,a} active-high; non-BCD codes are dark.
module segment_code
    import scan_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (bcd)
            4'd0: seg_c = 7'h3f;
            4'd1: seg_c = 7'h06;
            4'd2: seg_c = 7'h5b;
            4'd3: seg_c = 7'h4f;
            4'd4: seg_c = 7'h66;
            4'd5: seg_c = 7'h6d;
            4'd6: seg_c = 7'h7d;
            4'd7: seg_c = 7'h07;
            4'd8: seg_c = 7'h7f;
            4'd9: seg_c = 7'h6f;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/segment_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered digit values.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits.
module segment_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 6,
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    output logic [SEG_W-1:0]            seg,
    output logic [NUM_DIGITS-1:0]       dig_en,
    output logic                        frame_done
);

    localparam int unsigned CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t                              state, state_nxt;
    logic [IDX_W-1:0]                    idx, idx_nxt;
    logic [CNT_W-1:0]                    cnt, cnt_nxt;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]    active, pending;
    logic                                pend_valid;
    logic                                swap_c, frame_end_c;
    logic [SEG_W-1:0]                    code_c, shown_c, seg_nxt;
    logic [NUM_DIGITS-1:0]               dig_nxt;

    segment_code u_code (
        .bcd   (active[idx]),
        .seg_c (code_c)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant (lower index) digit is 0.
    logic [NUM_DIGITS-1:0] lead_zero_c;

    always_comb begin
        logic run;
        run         = 1'b1;
        lead_zero_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            run            = run & (active[i] == '0);
            lead_zero_c[i] = run;
        end
        lead_zero_c[NUM_DIGITS-1] = 1'b0;
    end

    assign shown_c = lead_zero_c[idx] ? SEG_OFF : code_c;
`else
    assign shown_c = code_c;
`endif

    // Next state plus next outputs; outputs follow the next state so seg and dig_en move together.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        swap_c      = 1'b0;
        frame_end_c = 1'b0;
        dig_nxt     = NUM_DIGITS'(DIG_OFF);
        seg_nxt     = SEG_OFF;

        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    swap_c    = pend_valid;
                end
                BLANK: begin
                    if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                        state_nxt = SHOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt == CNT_W'(PRESCALE - 1)) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                            idx_nxt     = '0;
                            frame_end_c = 1'b1;
                            swap_c      = pend_valid;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Entering or staying in SHOW keeps idx and active unchanged, so the current mux output is valid.
        if (state_nxt == SHOW) begin
            dig_nxt = NUM_DIGITS'(dig_sel(1'b1, 32'(idx)));
            seg_nxt = shown_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            seg        <= SEG_OFF;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            seg        <= seg_nxt;
            dig_en     <= dig_nxt;
            frame_done <= frame_end_c;
        end
    end

    // Double buffer: a load always lands in pending, even on the edge that copies pending to active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (swap_c) begin
                active <= pending;
            end
            if (load) begin
                pending    <= digits_in;
                pend_valid <= 1'b1;
            end else if (swap_c) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Self-checking bench for segment_scan_ctrl against a frame-time reference model.
module tb_segment_scan_ctrl;

    localparam int ND    = 6;
    localparam int PS    = 4;
    localparam int BC    = 1;
    localparam int SLOT  = PS + BC;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [23:0] digits_in;
    logic [6:0]  seg;
    logic [5:0]  dig_en;
    logic        frame_done;

    always #5 clk = ~clk;

    segment_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] code_tbl [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                  7'h7f, 7'h6f, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    // Reference model: m_t counts clocks since the scan started; everything derives from it.
    bit         m_run;
    int         m_t;
    logic [3:0] m_act  [ND];
    logic [3:0] m_pend [ND];
    bit         m_pv;

    bit         chk_on = 1'b0;
    int         pin_id = 0;
    string      pin_name;
    logic [6:0] pin_seg;
    logic [5:0] pin_dig;
    logic       pin_fd;

    task automatic model_reset();
        m_run = 1'b0;
        m_t   = 0;
        m_pv  = 1'b0;
        for (int i = 0; i < ND; i++) begin
            m_act[i]  = 4'h0;
            m_pend[i] = 4'h0;
        end
    endtask

    task automatic model_update(input bit en, input bit ld, input logic [23:0] din);
        bit swap;
        swap = 1'b0;
        if (!en) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
            swap  = m_pv;
        end else begin
            m_t  = m_t + 1;
            swap = (m_t % FRAME == 0) && m_pv;
        end
        if (swap) begin
            m_act = m_pend;
            m_pv  = 1'b0;
        end
        if (ld) begin
            for (int i = 0; i < ND; i++) m_pend[i] = din[4*i +: 4];
            m_pv = 1'b1;
        end
    endtask

    task automatic model_out(output logic [6:0] s, output logic [5:0] d, output logic f);
        int ph;
        int dg;
        bit allz;
        s = 7'h00;
        d = 6'h00;
        f = 1'b0;
        if (m_run) begin
            ph = m_t % SLOT;
            dg = (m_t / SLOT) % ND;
            f  = (m_t > 0) && (m_t % FRAME == 0);
            if (ph >= BC) begin
                d = 6'(1) << dg;
                s = code_tbl[m_act[dg]];
`ifdef LEADING_ZERO_BLANK_EN
                allz = 1'b1;
                for (int j = 0; j <= dg; j++) if (m_act[j] != 4'h0) allz = 1'b0;
                if (allz && dg != ND - 1) s = 7'h00;
`else
                allz = 1'b0;
`endif
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Single compare process: model every cycle, plus any pending hand-computed pin.
    initial begin : cmp_proc
        int         seen;
        logic [6:0] es;
        logic [5:0] ed;
        logic       ef;
        seen = 0;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                model_out(es, ed, ef);
                check("seg", 32'(seg), 32'(es));
                check("dig_en", 32'(dig_en), 32'(ed));
                check("frame_done", 32'(frame_done), 32'(ef));
            end
            if (pin_id != seen) begin
                seen = pin_id;
                check({pin_name, "_seg"}, 32'(seg), 32'(pin_seg));
                check({pin_name, "_dig"}, 32'(dig_en), 32'(pin_dig));
                check({pin_name, "_fd"}, 32'(frame_done), 32'(pin_fd));
            end
        end
    end

    task automatic pin(input string n, input logic [6:0] s, input logic [5:0] d, input logic f);
        pin_name = n;
        pin_seg  = s;
        pin_dig  = d;
        pin_fd   = f;
        pin_id   = pin_id + 1;
    endtask

    // Advance one edge: update the model with the inputs that edge sampled, then drive the next ones.
    task automatic tick(input bit en, input bit ld, input logic [23:0] din);
        @(posedge clk);
        #1;
        if (!rst) model_update(enable, load, digits_in);
        enable    = en;
        load      = ld;
        digits_in = din;
    endtask

    initial begin : main_proc
        bit          en;
        bit          ld;
        logic [23:0] din;
        logic [31:0] r;

        rst       = 1'b1;
        enable    = 1'b0;
        load      = 1'b0;
        digits_in = 24'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        pin("reset", 7'h00, 6'h00, 1'b0);
        tick(1'b0, 1'b0, 24'h0);
        rst = 1'b0;

        tick(1'b0, 1'b1, 24'h123456);
        tick(1'b1, 1'b0, 24'h0);

        // Directed run: after iteration k's edge the scan time is k.
        for (int k = 0; k < 200; k++) begin
            en  = (k < 197);
            ld  = 1'b0;
            din = 24'h0;
            case (k)
                64:  begin ld = 1'b1; din = 24'h999999; end
                95:  begin ld = 1'b1; din = 24'h111111; end
                100: begin ld = 1'b1; din = 24'h222222; end
                130: begin ld = 1'b1; din = 24'h000A00; end
                149: begin ld = 1'b1; din = 24'h876543; end
                default: ;
            endcase
            tick(en, ld, din);
            case (k)
                0:   pin("t0_blank",        7'h00, 6'b000000, 1'b0);
                1:   pin("d0_first",        7'h7d, 6'b000001, 1'b0);
                6:   pin("d1",              7'h6d, 6'b000010, 1'b0);
                26:  pin("d5",              7'h06, 6'b100000, 1'b0);
                29:  pin("d5_last",         7'h06, 6'b100000, 1'b0);
                30:  pin("frame_pulse1",    7'h00, 6'b000000, 1'b1);
                60:  pin("frame_pulse2",    7'h00, 6'b000000, 1'b1);
                81:  pin("mid_load_held",   7'h5b, 6'b010000, 1'b0);
                91:  pin("mid_load_shown",  7'h6f, 6'b000001, 1'b0);
                121: pin("last_load_wins",  7'h5b, 6'b000001, 1'b0);
                150: pin("frame_pulse5",    7'h00, 6'b000000, 1'b1);
                161: pin("nibble_a_dark",   7'h00, 6'b000100, 1'b0);
                181: pin("coincident_load", 7'h4f, 6'b000001, 1'b0);
                198: pin("disable_dark",    7'h00, 6'b000000, 1'b0);
                default: ;
            endcase
        end

        repeat (3) tick(1'b0, 1'b0, 24'h0);
        tick(1'b1, 1'b0, 24'h0);
        tick(1'b1, 1'b0, 24'h0);
        pin("reen_blank", 7'h00, 6'b000000, 1'b0);
        tick(1'b1, 1'b0, 24'h0);
        pin("reen_first", 7'h4f, 6'b000001, 1'b0);
        repeat (12) tick(1'b1, 1'b0, 24'h0);

        // Asynchronous reset in the middle of a lit slot.
        rst = 1'b1;
        model_reset();
        pin("rst_async", 7'h00, 6'b000000, 1'b0);
        tick(1'b0, 1'b0, 24'h0);
        tick(1'b0, 1'b1, 24'h000705);
        rst = 1'b0;
        tick(1'b0, 1'b0, 24'h0);
        tick(1'b1, 1'b0, 24'h0);
        tick(1'b1, 1'b0, 24'h0);
        tick(1'b1, 1'b0, 24'h0);
        pin("post_rst_first", 7'h6d, 6'b000001, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            r   = $urandom;
            din = r[23:0];
            if ($urandom_range(0, 3) == 0) din = din & 24'h0F00F0;
            en  = ($urandom_range(0, 63) != 0);
            ld  = ($urandom_range(0, 19) == 0);
            tick(en, ld, din);
        end

        repeat (2) tick(1'b0, 1'b0, 24'h0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
